// File: rtl/clock_divider_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side requests the run/divisor/sync, the slave side reports the divided clock.
interface clock_divider_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             sync;
  logic             clk_out;
  logic             rise_tick;
  logic             running;
  logic [CNT_W-1:0] div_active;

  modport master (
    output en, div_val, sync,
    input  clk_out, rise_tick, running, div_active
  );

  modport slave (
    input  en, div_val, sync,
    output clk_out, rise_tick, running, div_active
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with graceful stop, boundary-only divisor
// reload and a sync input for phase-aligning several instances.
module clock_divider_prog #(
  parameter int CNT_W     = 16,
  parameter int DIV_RESET = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  clock_divider_prog_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] n_eff_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             boundary_s;

  // Divisors below 2 are clamped so clk is never passed straight through.
  assign n_eff_s    = (bus.div_val < CNT_W'(2)) ? CNT_W'(2) : bus.div_val;
  assign cnt_inc_s  = cnt_q + CNT_W'(1);
  assign boundary_s = (cnt_q == (div_q - CNT_W'(1)));

  // Next-state and next-output logic; a restart always lands on cnt=0 with clk_out high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    clk_out_d = 1'b0;
    rise_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d   = RUN;
          cnt_d     = '0;
          div_d     = n_eff_s;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.en && (bus.sync || boundary_s)) begin
          state_d   = RUN;
          cnt_d     = '0;
          div_d     = n_eff_s;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end else if (boundary_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Mid-period: div_val and a lone en drop are ignored until the boundary.
          cnt_d     = cnt_inc_s;
          clk_out_d = (cnt_inc_s < (div_q >> 1));
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // State and output flops; reset aborts any period in progress immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= CNT_W'(DIV_RESET);
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      running_q <= running_d;
    end
  end

  assign bus.clk_out    = clk_out_q;
  assign bus.rise_tick  = rise_q;
  assign bus.running    = running_q;
  assign bus.div_active = div_q;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Parametrised, runtime-programmable integer clock divider.
- Generates a registered divided clock (`clk_out`) plus a single-cycle rising-edge strobe (`rise_tick`) in the source clock domain.
- Supports:
  - divisors 2..2^CNT_W-1;
  - an enable with graceful stop at the period boundary;
  - glitch-free divisor updates;
  - a phase-align (`sync`) input, so several instances can be started or realigned together.
- Sits beside the existing fixed divide-by-2 generator. It feeds sensor and ADC timing logic with slower, ratio-selectable clocks/enables.

Parameters:
- CNT_W, 16: width of divisor and period counter.
- DIV_RESET, 2: divisor reported on `div_active` after reset (must be >= 2).

Ports:
- clk  input  1  source clock; all logic is on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  run request; level-sensitive.
- div_val  input  CNT_W  requested divisor N; sampled only at period start.
- sync  input  1  phase-align pulse; restarts the period on the next cycle.
- clk_out  output  1  divided clock, registered.
- rise_tick  output  1  high for exactly one clk cycle, coincident with each rising edge of `clk_out`.
- running  output  1  high while a period is in progress (state RUN).
- div_active  output  CNT_W  divisor applied to the current period.

Behaviour:
- Reset (rstn low, asynchronous):
  - clk_out=0, rise_tick=0, running=0, div_active=DIV_RESET;
  - internal counter=0, state=IDLE.
- Reset release is synchronous to the next clk edge. Reset mid-period aborts immediately; no completion is attempted.
- Divisor clamp: N_eff = (div_val < 2) ? 2 : div_val. No bypass mode; `clk` is never passed through to `clk_out`.
- Duty cycle:
  - H = floor(N_eff/2) cycles high, L = N_eff - H cycles low.
  - Even N gives exactly 50%. Odd N is low-biased by one cycle, e.g. N=5 gives 2 high, 3 low.
- States: IDLE, RUN.
- IDLE:
  - clk_out=0, running=0.
  - If en=1 at edge k: at edge k+1 enter RUN, load div_active=N_eff, cnt=0, clk_out=1, rise_tick=1. Latency from en to first rising edge is one cycle.
- RUN:
  - cnt increments each cycle, 0..N_eff-1.
  - clk_out = (cnt < H).
  - rise_tick = (cnt == 0), for one cycle only.
- Period boundary (cnt == div_active-1):
  - if en=1: cnt wraps to 0, div_active reloads from clamped div_val, new period starts (clk_out=1, rise_tick=1);
  - if en=0: go to IDLE, clk_out stays 0, running=0.
- en deasserted mid-period: the current period runs to completion. No truncated high or low phase.
- div_val changed mid-period: ignored until the next boundary. The output never has a runt pulse.
- sync=1 in RUN with en=1 at edge k: at edge k+1 cnt=0, div_active reloads, clk_out=1, rise_tick=1. The current period is truncated, which is the intended phase alignment. Asserting sync during the first cycle of a period leaves only that period's first cycle, then restarts.
- sync in IDLE: behaves like the en start, but only if en=1; otherwise ignored.
- sync and boundary in the same cycle: same result (restart). en=0 at the same cycle takes precedence, giving IDLE.
- Counter arithmetic is unsigned CNT_W bits; cnt never exceeds div_active-1, so no overflow is possible.
- All outputs are driven directly from flops.

Test Plan:
- Reset, en=1, div_val=2 -> from edge k+1, clk_out = 1,0,1,0...; rise_tick every 2nd cycle, matching the legacy divide-by-2 waveform. Assert rstn=0 mid-high -> clk_out=0 immediately, div_active=2.
- div_val=5, en=1 -> clk_out pattern 1,1,0,0,0 repeating; rise_tick period 5, one cycle wide. div_val=0 and div_val=1 -> identical to N=2, div_active=2.
- Running N=4, change div_val to 6 at cnt=1 -> current period finishes as 1,1,0,0; next period is 1,1,1,0,0,0; div_active changes 4->6 exactly on the rise_tick cycle.
- Running N=8, drop en at cnt=2 -> high for cycles 0..3, low 4..7, then IDLE with running=0 and clk_out held 0. Reassert en -> first rise one cycle later.
- Two instances (N=6 and N=3) started at different times, then a common sync pulse -> both assert rise_tick on the same cycle after sync and stay aligned every 6 cycles.
- sync with en=0 at the boundary cycle -> IDLE entered, no rise_tick.
